// File: rtl/ps2_device_tx.sv
// PS/2 device-to-host transmitter: sends one byte as an 11-bit frame on open-drain
// ps2_clk/ps2_data, generating the clock itself and yielding to host inhibit.
module ps2_device_tx #(
  parameter int HALF_PERIOD = 2000,
  parameter int IDLE_HOLD   = 2500,
  parameter int CNT_W       = 12
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        ps2_clk,
  inout  wire        ps2_data,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       inject_parity_err,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_abort
);

  // state    | meaning
  // IDLE     | ready for a byte, lines released
  // WAIT_BUS | waiting for IDLE_HOLD cycles of quiet bus
  // BIT_HIGH | clock released, data presented, inhibit checked on last cycle
  // BIT_LOW  | device holds clock low, host samples on the falling edge
  // TAIL     | lines released for one half period after the stop bit
  // ABORT    | one-cycle release after host inhibit
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BUS, S_BIT_HIGH, S_BIT_LOW, S_TAIL, S_ABORT
  } state_t;

  localparam logic [CNT_W-1:0] HP_LAST = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] IH_LAST = CNT_W'(IDLE_HOLD - 1);

  state_t            state_q, state_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [3:0]        bit_idx_q, bit_idx_nxt;
  logic [10:0]       frame_q, frame_nxt;
  logic              done_q, done_nxt;
  logic              abort_q, abort_nxt;
  logic              clk_low, data_low;
  logic              ps2_clk_in, ps2_data_in;
  logic              hp_last;

  assign ps2_clk_in  = ps2_clk;
  assign ps2_data_in = ps2_data;
  assign ps2_clk     = clk_low  ? 1'b0 : 1'bz;
  assign ps2_data    = data_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      frame_q   <= '1;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      bit_idx_q <= bit_idx_nxt;
      frame_q   <= frame_nxt;
      done_q    <= done_nxt;
      abort_q   <= abort_nxt;
    end
  end

  assign hp_last = (cnt_q == HP_LAST);

  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    bit_idx_nxt = bit_idx_q;
    frame_nxt   = frame_q;
    done_nxt    = 1'b0;
    abort_nxt   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          frame_nxt = {1'b1, (~^tx_data) ^ inject_parity_err, tx_data, 1'b0};
          cnt_nxt   = '0;
          state_nxt = S_WAIT_BUS;
        end
      end
      S_WAIT_BUS: begin
        // Any low on either line restarts the quiet-bus window; never aborts.
        if (!(ps2_clk_in && ps2_data_in)) begin
          cnt_nxt = '0;
        end else if (cnt_q == IH_LAST) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = S_BIT_HIGH;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      S_BIT_HIGH: begin
        if (hp_last) begin
          cnt_nxt = '0;
          if (!ps2_clk_in) state_nxt = S_ABORT;
          else             state_nxt = S_BIT_LOW;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      S_BIT_LOW: begin
        if (hp_last) begin
          cnt_nxt = '0;
          if (bit_idx_q == 4'd10) begin
            state_nxt = S_TAIL;
          end else begin
            bit_idx_nxt = bit_idx_q + 4'd1;
            state_nxt   = S_BIT_HIGH;
          end
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      S_TAIL: begin
        if (hp_last) begin
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      S_ABORT: begin
        cnt_nxt   = '0;
        abort_nxt = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_ready = (state_q == S_IDLE);
    clk_low  = (state_q == S_BIT_LOW);
    data_low = ((state_q == S_BIT_HIGH) || (state_q == S_BIT_LOW)) && !frame_q[bit_idx_q];
    tx_done  = done_q;
    tx_abort = abort_q;
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: cycle-level frame model plus a falling-edge host sampler,
// with directed scenarios for nominal, parity, inhibit, reset and back-to-back sends.
module tb_ps2_device_tx;

  localparam int HP = 8;
  localparam int IH = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       inject_parity_err;
  logic       tx_ready, tx_done, tx_abort;
  logic       host_clk_low;
  wire        ps2_clk;
  wire        ps2_data;

  pullup (ps2_clk);
  pullup (ps2_data);
  assign ps2_clk = host_clk_low ? 1'b0 : 1'bz;

  ps2_device_tx #(.HALF_PERIOD(HP), .IDLE_HOLD(IH), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .tx_data(tx_data), .tx_valid(tx_valid), .inject_parity_err(inject_parity_err),
    .tx_ready(tx_ready), .tx_done(tx_done), .tx_abort(tx_abort)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests, n_fail;
  bit chk_en;
  bit host_q[$];

  // frame model: timeline expressed as offsets from the frame start cycle
  bit          m_busy, m_aborted;
  logic [10:0] m_frame;
  int          m_start, m_end, m_done_cyc, m_abort_cyc;

  int n_done, n_abort, last_done_cyc, last_abort_cyc, last_clk_low_cyc, first_fall_cyc;
  int acc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic host_loop();
    forever begin
      @(negedge ps2_clk);
      if (chk_en && !host_clk_low) host_q.push_back(ps2_data);
    end
  endtask

  task automatic compare_loop();
    int   c, j;
    logic dev_clk_low, dev_data_low, prev_data;
    prev_data = 1'b1;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        c = cyc;
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
        j = c - m_start;
        if (m_busy && !m_aborted && j >= 0 && j < 22*HP) begin
          dev_clk_low  = (j % (2*HP)) >= HP;
          dev_data_low = !m_frame[j / (2*HP)];
        end
        check("ps2_clk",  {31'b0, ps2_clk},  {31'b0, !(dev_clk_low || host_clk_low)});
        check("ps2_data", {31'b0, ps2_data}, {31'b0, !dev_data_low});
        check("tx_ready", {31'b0, tx_ready}, {31'b0, !m_busy});
        check("tx_done",  {31'b0, tx_done},  {31'b0, c == m_done_cyc});
        check("tx_abort", {31'b0, tx_abort}, {31'b0, c == m_abort_cyc});

        if (tx_done === 1'b1)  begin n_done++;  last_done_cyc = c;  end
        if (tx_abort === 1'b1) begin n_abort++; last_abort_cyc = c; end
        if (ps2_clk === 1'b0 && !host_clk_low) last_clk_low_cyc = c;
        if (ps2_data === 1'b0 && prev_data === 1'b1 && first_fall_cyc < 0) first_fall_cyc = c;
        prev_data = ps2_data;

        if (rst) begin
          m_busy = 0; m_done_cyc = -1; m_abort_cyc = -1;
        end else if (!m_busy) begin
          if (tx_valid) begin
            m_busy    = 1;
            m_aborted = 0;
            m_frame   = {1'b1, (($countones(tx_data) % 2) == 0) ^ inject_parity_err, tx_data, 1'b0};
            m_start   = c + 1 + IH;
            m_end     = m_start + 23*HP;
          end
        end else begin
          if (c < m_start && host_clk_low) begin
            m_start = c + 1 + IH;
            m_end   = m_start + 23*HP;
          end else if (!m_aborted && j >= 0 && j < 22*HP && (j % (2*HP)) == HP-1 && host_clk_low) begin
            m_aborted = 1;
            m_end     = c + 2;
          end
          if (c == m_end - 1) begin
            m_busy = 0;
            if (m_aborted) m_abort_cyc = c + 1;
            else           m_done_cyc  = c + 1;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic send(input logic [7:0] d, input logic inj);
    tx_data = d; inject_parity_err = inj; tx_valid = 1'b1;
    acc = cyc;
    tick();
    tx_valid = 1'b0; inject_parity_err = 1'b0;
  endtask

  task automatic check_frame(input string nm, input logic [10:0] exp_w,
                             input logic [7:0] exp_byte, input logic exp_perr);
    logic [10:0] w;
    w = '0;
    for (int i = 0; i < 11; i++) if (i < host_q.size()) w[i] = host_q[i];
    check({nm, "_edges"}, host_q.size(), 11);
    check({nm, "_bits"}, {21'b0, w}, {21'b0, exp_w});
    check({nm, "_byte"}, {24'b0, w[8:1]}, {24'b0, exp_byte});
    check({nm, "_perr"}, {31'b0, ~^w[9:1]}, {31'b0, exp_perr});
  endtask

  int done_b, abort_b, saved_low, a1;

  initial begin
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; inject_parity_err = 1'b0; host_clk_low = 1'b0;
    chk_en = 0; n_tests = 0; n_fail = 0;
    m_busy = 0; m_aborted = 0; m_frame = '1; m_start = 0; m_end = 0;
    m_done_cyc = -1; m_abort_cyc = -1;
    n_done = 0; n_abort = 0; last_done_cyc = -1; last_abort_cyc = -1;
    last_clk_low_cyc = -1; first_fall_cyc = -1;
    fork
      host_loop();
      compare_loop();
    join_none
    repeat (2) tick();
    chk_en = 1;
    @(negedge clk);
    check("rst_ready", {31'b0, tx_ready}, 1);
    check("rst_done",  {31'b0, tx_done}, 0);
    check("rst_abort", {31'b0, tx_abort}, 0);
    check("rst_clk",   {31'b0, ps2_clk}, 1);
    check("rst_data",  {31'b0, ps2_data}, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(); tick();

    host_q.delete(); send(8'hA5, 1'b0); run_to(acc + 197);
    check_frame("nominal", 11'h74A, 8'hA5, 1'b0);
    check("nominal_done_cyc", last_done_cyc, acc + 195);

    host_q.delete(); send(8'h00, 1'b0); run_to(acc + 197);
    check_frame("zero", 11'h600, 8'h00, 1'b0);
    host_q.delete(); send(8'hFF, 1'b0); run_to(acc + 197);
    check_frame("ones", 11'h7FE, 8'hFF, 1'b0);

    host_q.delete(); send(8'hA5, 1'b1); run_to(acc + 197);
    check_frame("inject", 11'h54A, 8'hA5, 1'b1);

    abort_b = n_abort; first_fall_cyc = -1; host_q.delete();
    host_clk_low = 1'b1;
    send(8'h3C, 1'b0);
    run_to(acc + 40);
    host_clk_low = 1'b0;
    run_to(acc + 236);
    check("preinh_first_drive", first_fall_cyc, acc + 50);
    check_frame("preinh", 11'h678, 8'h3C, 1'b0);
    check("preinh_done_cyc", last_done_cyc, acc + 234);
    check("preinh_no_abort", n_abort, abort_b);

    done_b = n_done; abort_b = n_abort; host_q.delete();
    send(8'h96, 1'b0);
    run_to(acc + 78);
    host_clk_low = 1'b1;
    run_to(acc + 100);
    host_clk_low = 1'b0;
    tick();
    check("midinh_abort_cyc", last_abort_cyc, acc + 84);
    check("midinh_abort_cnt", n_abort, abort_b + 1);
    check("midinh_no_done", n_done, done_b);
    check("midinh_edges", host_q.size(), 4);
    @(negedge clk);
    check("midinh_ready", {31'b0, tx_ready}, 1);
    @(posedge clk); #1;

    done_b = n_done; abort_b = n_abort; host_q.delete();
    send(8'h81, 1'b0);
    run_to(acc + 117);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_clk",   {31'b0, ps2_clk}, 1);
    check("midrst_data",  {31'b0, ps2_data}, 1);
    check("midrst_ready", {31'b0, tx_ready}, 1);
    @(posedge clk); #1;
    run_to(acc + 200);
    check("midrst_no_done", n_done, done_b);
    check("midrst_no_abort", n_abort, abort_b);

    host_q.delete();
    send(8'h5A, 1'b0); a1 = acc;
    run_to(a1 + 195);
    check_frame("b2b_first", 11'h6B4, 8'h5A, 1'b0);
    saved_low = last_clk_low_cyc;
    first_fall_cyc = -1; host_q.delete();
    send(8'hC3, 1'b0);
    check("b2b_accept_cyc", acc, a1 + 195);
    run_to(acc + 197);
    check_frame("b2b_second", 11'h786, 8'hC3, 1'b0);
    check("b2b_done_cyc", last_done_cyc, acc + 195);
    check("b2b_gap_ok", {31'b0, (first_fall_cyc - saved_low - 1) >= (HP + IH)}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
